// File: rtl/key_event_filter.sv
// Per-key conditioner for the raw push-button lines.
// Each channel is synchronised and debounced, then produces a level and press, release and auto-repeat pulses.
module key_event_filter #(
  parameter int unsigned NUM_KEYS        = 4,
  parameter bit          ACTIVE_LOW      = 1'b0,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] key_pressed,
  output logic [NUM_KEYS-1:0] key_released,
  output logic [NUM_KEYS-1:0] key_repeat
);

  localparam int unsigned DB_W        = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned DB_LAST     = DEBOUNCE_CYCLES - 1;
  localparam int unsigned RP_MAX      = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RP_W        = $clog2(RP_MAX + 1);
  localparam int unsigned DELAY_LOAD  = (REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0;
  localparam int unsigned PERIOD_LOAD = REPEAT_PERIOD - 1;
  localparam bit          REPEAT_EN   = (REPEAT_DELAY != 0);

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;

  logic [NUM_KEYS-1:0] key_c;

  // Polarity correction ahead of the synchroniser so every later stage sees 1 = pressed.
  assign key_c = ACTIVE_LOW ? ~key : key;

  genvar g;
  for (g = 0; g < int'(NUM_KEYS); g++) begin : g_chan
    logic            sync1_q, sync2_q;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            state_q, state_d;
    logic            press_q, press_d;
    logic            rel_q, rel_d;
    logic            rpt_q, rpt_d;
    logic [RP_W-1:0] rp_cnt_q, rp_cnt_d;
    rpt_state_e      fsm_q, fsm_d;
    logic            toggle_c;

    // State register for synchroniser, debounce, pulses and repeat FSM.
    always_ff @(posedge clock) begin
      if (reset) begin
        sync1_q  <= 1'b0;
        sync2_q  <= 1'b0;
        db_cnt_q <= '0;
        state_q  <= 1'b0;
        press_q  <= 1'b0;
        rel_q    <= 1'b0;
        rpt_q    <= 1'b0;
        rp_cnt_q <= '0;
        fsm_q    <= RPT_IDLE;
      end else begin
        sync1_q  <= key_c[g];
        sync2_q  <= sync1_q;
        db_cnt_q <= db_cnt_d;
        state_q  <= state_d;
        press_q  <= press_d;
        rel_q    <= rel_d;
        rpt_q    <= rpt_d;
        rp_cnt_q <= rp_cnt_d;
        fsm_q    <= fsm_d;
      end
    end

    // Next-state logic: debounce accepts a change after DEBOUNCE_CYCLES consecutive mismatches.
    always_comb begin
      db_cnt_d = '0;
      state_d  = state_q;
      toggle_c = 1'b0;
      press_d  = 1'b0;
      rel_d    = 1'b0;
      rpt_d    = 1'b0;
      rp_cnt_d = rp_cnt_q;
      fsm_d    = fsm_q;

      if (sync2_q != state_q) begin
        if (db_cnt_q == DB_W'(DB_LAST)) begin
          toggle_c = 1'b1;
          state_d  = ~state_q;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end

      press_d = toggle_c & ~state_q;
      rel_d   = toggle_c & state_q;

      // A release wins over everything so no repeat can land in the release cycle.
      if (rel_d) begin
        fsm_d    = RPT_IDLE;
        rp_cnt_d = '0;
      end else begin
        case (fsm_q)
          RPT_IDLE: begin
            if (press_d && REPEAT_EN) begin
              fsm_d    = RPT_DELAY;
              rp_cnt_d = RP_W'(DELAY_LOAD);
            end
          end
          RPT_DELAY, RPT_REPEAT: begin
            if (rp_cnt_q == '0) begin
              rpt_d    = 1'b1;
              fsm_d    = RPT_REPEAT;
              rp_cnt_d = RP_W'(PERIOD_LOAD);
            end else begin
              rp_cnt_d = rp_cnt_q - RP_W'(1);
            end
          end
          default: begin
            fsm_d    = RPT_IDLE;
            rp_cnt_d = '0;
          end
        endcase
      end
    end

    assign key_state[g]    = state_q;
    assign key_pressed[g]  = press_q;
    assign key_released[g] = rel_q;
    assign key_repeat[g]   = rpt_q;
  end

endmodule

// File: tb/tb_key_event_filter.sv
// Bench for key_event_filter: directed scenarios plus random key activity,
// checked every cycle against a sliding-window / arithmetic reference model.
module tb_key_event_filter;

  localparam int NK   = 4;
  localparam int DB   = 4;
  localparam int RD   = 10;
  localparam int RP   = 3;
  localparam int NCH  = 2 * NK;
  localparam int MAXE = 16384;

  logic clock = 1'b0;
  logic reset;
  logic [NK-1:0] key_a, key_b;
  logic [NK-1:0] st_a, pr_a, rl_a, rp_a;
  logic [NK-1:0] st_b, pr_b, rl_b, rp_b;

  always #5 clock = ~clock;

  key_event_filter #(
    .NUM_KEYS(NK), .ACTIVE_LOW(1'b0), .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) u_dut_hi (
    .clock(clock), .reset(reset), .key(key_a),
    .key_state(st_a), .key_pressed(pr_a), .key_released(rl_a), .key_repeat(rp_a)
  );

  key_event_filter #(
    .NUM_KEYS(NK), .ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) u_dut_lo (
    .clock(clock), .reset(reset), .key(key_b),
    .key_state(st_b), .key_pressed(pr_b), .key_released(rl_b), .key_repeat(rp_b)
  );

  int checks = 0;
  int errors = 0;

  // Model: per channel, the history of synchronised samples and the time of the last press.
  bit   samp [NCH][MAXE];
  bit   m_st [NCH];
  int   m_pedge [NCH];
  int   n_edge;
  logic [NCH-1:0] e_st, e_pr, e_rl, e_rp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // A level is accepted once the last DB synchronised samples all differ from it;
  // repeats fall at press + RD + k*RP while the level stays pressed.
  task automatic model_edge();
    bit raw, mism;
    n_edge++;
    if (n_edge >= MAXE) begin
      $display("FAIL edge_budget: observed %0d expected below %0d", n_edge, MAXE);
      $fatal(1);
    end
    e_pr = '0;
    e_rl = '0;
    e_rp = '0;
    for (int c = 0; c < NCH; c++) begin
      if (c < NK) raw = key_a[c];
      else        raw = ~key_b[c-NK];
      if (reset) begin
        samp[c][n_edge]   = 1'b0;
        samp[c][n_edge-1] = 1'b0;
        m_st[c]           = 1'b0;
        m_pedge[c]        = -1;
      end else begin
        samp[c][n_edge] = raw;
        mism = 1'b1;
        for (int k = 2; k <= DB + 1; k++)
          if (samp[c][n_edge-k] == m_st[c]) mism = 1'b0;
        if (mism) begin
          m_st[c] = !m_st[c];
          if (m_st[c]) begin
            e_pr[c]    = 1'b1;
            m_pedge[c] = n_edge;
          end else begin
            e_rl[c]    = 1'b1;
            m_pedge[c] = -1;
          end
        end else if (m_st[c] && m_pedge[c] >= 0 && (n_edge - m_pedge[c]) >= RD
                     && ((n_edge - m_pedge[c] - RD) % RP) == 0) begin
          e_rp[c] = 1'b1;
        end
      end
      e_st[c] = m_st[c];
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    model_edge();
    chk("state_hi",   32'(st_a), 32'(e_st[NK-1:0]));
    chk("press_hi",   32'(pr_a), 32'(e_pr[NK-1:0]));
    chk("release_hi", 32'(rl_a), 32'(e_rl[NK-1:0]));
    chk("repeat_hi",  32'(rp_a), 32'(e_rp[NK-1:0]));
    chk("state_lo",   32'(st_b), 32'(e_st[NCH-1:NK]));
    chk("press_lo",   32'(pr_b), 32'(e_pr[NCH-1:NK]));
    chk("release_lo", 32'(rl_b), 32'(e_rl[NCH-1:NK]));
    chk("repeat_lo",  32'(rp_b), 32'(e_rp[NCH-1:NK]));
    chk("press_rpt_excl", 32'(pr_a & rp_a), 32'd0);
  endtask

  initial begin
    int   got, nrep, nrel, rep_after, seen_rel;
    logic [31:0] acc, mask, exp_mask;
    int   run [NCH];
    logic lvl [NCH];

    reset  = 1'b1;
    key_a  = '0;
    key_b  = '1;
    n_edge = DB + 2;
    for (int c = 0; c < NCH; c++) m_pedge[c] = -1;
    step();
    step();
    chk("rst_state",  32'(st_a), 32'd0);
    chk("rst_press",  32'(pr_a), 32'd0);
    chk("rst_repeat", 32'(rp_a), 32'd0);
    chk("rst_state_lo", 32'(st_b), 32'd0);
    reset = 1'b0;

    // Clean press on channel 0: accepted after edge DB+2.
    key_a = 4'b0001;
    for (int i = 1; i <= DB + 1; i++) begin
      step();
      chk("clean_wait", 32'(st_a), 32'd0);
    end
    step();
    chk("clean_state", 32'(st_a), 32'b0001);
    chk("clean_press", 32'(pr_a), 32'b0001);
    step();
    chk("clean_press_width", 32'(pr_a), 32'd0);
    key_a = 4'b0000;
    nrel = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (rl_a[0]) nrel++;
    end
    chk("clean_release_once", 32'(nrel), 32'd1);

    // Glitch of 3 cycles is dropped; 4 cycles is accepted.
    key_a = 4'b0010;
    acc = '0;
    for (int i = 0; i < 3; i++) begin step(); acc |= 32'(st_a | pr_a | rl_a); end
    key_a = 4'b0000;
    for (int i = 0; i < 8; i++) begin step(); acc |= 32'(st_a | pr_a | rl_a); end
    chk("glitch_rejected", acc, 32'd0);
    key_a = 4'b0010;
    got = 0; nrel = 0;
    for (int i = 0; i < 4; i++) begin step(); if (pr_a[1]) got++; end
    key_a = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      step();
      if (pr_a[1]) got++;
      if (rl_a[1]) nrel++;
    end
    chk("glitch4_press", 32'(got), 32'd1);
    chk("glitch4_release", 32'(nrel), 32'd1);

    // Auto-repeat on channel 2.
    key_a = 4'b0100;
    got = 0;
    for (int i = 0; i < 12 && got == 0; i++) begin step(); if (pr_a[2]) got = 1; end
    chk("rpt_press_seen", 32'(got), 32'd1);
    mask = '0;
    for (int i = 1; i <= 24; i++) begin
      step();
      if (rp_a[2]) mask |= (32'd1 << i);
    end
    exp_mask = (32'd1 << 10) | (32'd1 << 13) | (32'd1 << 16) | (32'd1 << 19) | (32'd1 << 22);
    chk("rpt_positions", mask, exp_mask);
    key_a = 4'b0000;
    nrel = 0; seen_rel = 0; rep_after = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (rl_a[2]) begin nrel++; seen_rel = 1; end
      if (seen_rel != 0 && rp_a[2]) rep_after++;
    end
    chk("rpt_release_once", 32'(nrel), 32'd1);
    chk("rpt_none_after_release", 32'(rep_after), 32'd0);

    // Simultaneous keys 0 and 3.
    key_a = 4'b1001;
    for (int i = 0; i < DB + 1; i++) step();
    step();
    chk("simul_press", 32'(pr_a), 32'b1001);
    key_a = 4'b0000;
    for (int i = 0; i < 8; i++) step();

    // Active-low instance: only channel 0 is pressed.
    key_b = 4'b1110;
    for (int i = 0; i < DB + 1; i++) step();
    step();
    chk("lo_press", 32'(pr_b), 32'b0001);
    chk("lo_state", 32'(st_b), 32'b0001);
    chk("lo_hi_quiet", 32'(pr_a), 32'd0);
    key_b = 4'b1111;
    for (int i = 0; i < 8; i++) step();

    // Reset while channel 2 is auto-repeating; still held, so it is pressed again.
    key_a = 4'b0100;
    for (int i = 0; i < DB + 2; i++) step();
    for (int i = 0; i < 12; i++) step();
    reset = 1'b1;
    step();
    chk("rst_mid_state",   32'(st_a), 32'd0);
    chk("rst_mid_press",   32'(pr_a), 32'd0);
    chk("rst_mid_release", 32'(rl_a), 32'd0);
    chk("rst_mid_repeat",  32'(rp_a), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < DB + 1; i++) begin
      step();
      chk("rst_mid_wait", 32'(st_a), 32'd0);
    end
    step();
    chk("rst_repress", 32'(pr_a), 32'b0100);
    key_a = 4'b0000;
    for (int i = 0; i < 8; i++) step();

    // Random activity on all eight channels with occasional resets.
    for (int c = 0; c < NCH; c++) begin
      run[c] = 0;
      lvl[c] = 1'b0;
    end
    for (int t = 0; t < 3000; t++) begin
      for (int c = 0; c < NCH; c++) begin
        if (run[c] == 0) begin
          lvl[c] = 1'($urandom_range(0, 1));
          run[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 40))
                                              : int'($urandom_range(1, 8));
        end
        run[c]--;
        if (c < NK) key_a[c]    = lvl[c];
        else        key_b[c-NK] = ~lvl[c];
      end
      reset = ($urandom_range(0, 399) == 0);
      step();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
